jk_bank_ctrl: RTL and testbench

Command-driven sequencer for a bank of WIDTH JK flip-flops. Accepts LOAD, CLEAR, TOGGLE and COUNT commands over a valid/ready handshake. Translates each command into per-bit J/K drive for a fixed number of cycles, then pulses done. It sits between a host/test-controller and the JK storage bank, and exposes the bank contents as q.

---
 rtl/jk_bank_ctrl_pkg.sv | 29 ++
 rtl/jk_bank_ctrl_jk_ff.sv | 42 ++++
 rtl/jk_bank_ctrl.sv | 175 +++++++++++++++++
 tb/tb_jk_bank_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_bank_ctrl_pkg.sv
// Purpose: shared opcodes, FSM state encodings and small helpers for the JK bank sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jk_bank_ctrl_pkg;

  // Command opcodes as carried on cmd_op.
  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_CLEAR  = 2'b01,
    OP_TOGGLE = 2'b10,
    OP_COUNT  = 2'b11
  } op_t;

  // Sequencer states.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Fixed-length commands always run for exactly one EXEC cycle.
  localparam int unsigned SINGLE_CYCLE_LEN = 1;

  // True for commands whose EXEC length comes from cmd_len.
  function automatic logic op_uses_len(input op_t op);
    return (op == OP_COUNT);
  endfunction

endpackage

// File: rtl/jk_bank_ctrl_jk_ff.sv
// Purpose: single JK flip-flop storage cell (00 hold, 01 reset, 10 set, 11 toggle).
// Latency: q updates on the rising clk edge after j/k are applied.
// Backpressure: none; the cell samples j/k every cycle.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset, clears q
//   j, k - JK drive inputs
//   q    - stored bit
module jk_ff (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    unique case ({j, k})
      2'b00:   q_d = q_q;
      2'b01:   q_d = 1'b0;
      2'b10:   q_d = 1'b1;
      2'b11:   q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_bank_ctrl.sv
// Purpose: command sequencer that turns LOAD/CLEAR/TOGGLE/COUNT into per-bit J/K drive for a JK bank.
// Latency: accept at edge t, result in q after edge t+N, done high in cycle t+N+1 (N = EXEC length).
// Backpressure: cmd_ready is high only in IDLE; one command in flight, min spacing N+2 cycles.
//
// Ports:
//   clk, rst            - rising-edge clock, asynchronous active-low reset
//   cmd_valid/cmd_ready - command handshake; op/data/len sampled only on the accepting edge
//   cmd_op              - 00 LOAD, 01 CLEAR_MASK, 10 TOGGLE_MASK, 11 COUNT
//   cmd_data            - load value or bit mask (ignored for COUNT)
//   cmd_len             - COUNT length in cycles (ignored for other ops)
//   q                   - bank contents
//   j_mon, k_mon        - J/K vectors currently driven into the bank
//   busy                - high in EXEC and DONE
//   done                - one-cycle completion pulse
module jk_bank_ctrl
  import jk_bank_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_len,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j_mon,
  output logic [WIDTH-1:0] k_mon,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  // COUNT with zero length still spends one EXEC cycle, but drives nothing.
  logic             nop_q, nop_d;

  logic             accept;
  op_t              cmd_op_e;
  logic [WIDTH-1:0] cnt_en;
  logic [WIDTH-1:0] j_d, k_d;
  logic             bank_rst;

  assign cmd_op_e  = op_t'(cmd_op);
  assign cmd_ready = (state_q == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_q != S_IDLE);
  // State is a register, so done is a registered, glitch-free pulse.
  assign done      = (state_q == S_DONE);

  // ---------------------------------------------------------------------------
  // FSM + remaining-cycles counter: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    rem_d   = rem_q;
    nop_d   = nop_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_EXEC;
          op_d    = cmd_op_e;
          data_d  = cmd_data;
          if (op_uses_len(cmd_op_e)) begin
            nop_d = (cmd_len == '0);
            rem_d = (cmd_len == '0) ? CNT_W'(SINGLE_CYCLE_LEN) : cmd_len;
          end else begin
            nop_d = 1'b0;
            rem_d = CNT_W'(SINGLE_CYCLE_LEN);
          end
        end
      end
      S_EXEC: begin
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_LOAD;
      data_q  <= '0;
      rem_q   <= '0;
      nop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      nop_q   <= nop_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Counter toggle enables: bit i toggles when all lower bits are one.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic carry;
    carry  = 1'b1;
    cnt_en = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_en[i] = carry;
      carry     = carry & q[i];
    end
  end

  // ---------------------------------------------------------------------------
  // J/K drive: only EXEC drives the bank; IDLE and DONE hold it.
  // ---------------------------------------------------------------------------
  always_comb begin
    j_d = '0;
    k_d = '0;
    if (state_q == S_EXEC) begin
      unique case (op_q)
        OP_LOAD: begin
          j_d = data_q;
          k_d = ~data_q;
        end
        OP_CLEAR: begin
          j_d = '0;
          k_d = data_q;
        end
        OP_TOGGLE: begin
          j_d = data_q;
          k_d = data_q;
        end
        OP_COUNT: begin
          if (!nop_q) begin
            j_d = cnt_en;
            k_d = cnt_en;
          end
        end
        default: begin
          j_d = '0;
          k_d = '0;
        end
      endcase
    end
  end

  assign j_mon = j_d;
  assign k_mon = k_d;

  // ---------------------------------------------------------------------------
  // JK storage bank
  // ---------------------------------------------------------------------------
  assign bank_rst = ~rst;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    jk_ff u_ff (
      .clk (clk),
      .rst (bank_rst),
      .j   (j_d[gi]),
      .k   (k_d[gi]),
      .q   (q[gi])
    );
  end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
module tb_jk_bank_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_len;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] j_mon;
  logic [WIDTH-1:0] k_mon;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;
  int trace [0:63];

  jk_bank_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .q         (q),
    .j_mon     (j_mon),
    .k_mon     (k_mon),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: tracks bank value, EXEC cycles left and the done cycle.
  // ---------------------------------------------------------------------------
  int m_q    = 0;
  int m_left = 0;
  bit m_done = 1'b0;
  int m_op   = 0;
  int m_data = 0;
  bit m_nop  = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q    = 0;
      m_left = 0;
      m_done = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      case (m_op)
        0: m_q = m_data;
        1: m_q = m_q & ~m_data & MASK;
        2: m_q = (m_q ^ m_data) & MASK;
        default: if (!m_nop) m_q = (m_q + 1) & MASK;
      endcase
      m_left = m_left - 1;
      if (m_left == 0) m_done = 1'b1;
    end else if (cmd_valid) begin
      m_op   = int'(cmd_op);
      m_data = int'(cmd_data);
      m_nop  = (cmd_op == 2'b11) && (cmd_len == 0);
      m_left = (cmd_op == 2'b11) ? ((cmd_len == 0) ? 1 : int'(cmd_len)) : 1;
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    int ej, ek;
    forever begin
      @(negedge clk);
      #1;
      ej = 0;
      ek = 0;
      if (m_left > 0) begin
        case (m_op)
          0: begin ej = m_data; ek = ~m_data & MASK; end
          1: begin ej = 0;      ek = m_data;         end
          2: begin ej = m_data; ek = m_data;         end
          default: begin
            // bits that change on increment are exactly the toggling bits
            ej = m_nop ? 0 : (((m_q + 1) ^ m_q) & MASK);
            ek = ej;
          end
        endcase
      end
      chk("mdl_q",     int'(q),         m_q);
      chk("mdl_busy",  int'(busy),      int'((m_left > 0) || m_done));
      chk("mdl_done",  int'(done),      int'(m_done));
      chk("mdl_ready", int'(cmd_ready), int'((m_left == 0) && !m_done));
      chk("mdl_j",     int'(j_mon),     ej);
      chk("mdl_k",     int'(k_mon),     ek);
    end
  end

  // Issue one command from IDLE; lat = negedges from accept until done is seen.
  task automatic run_cmd(input logic [1:0] op, input logic [WIDTH-1:0] data,
                         input logic [CNT_W-1:0] len, input bit hold, output int lat);
    @(negedge clk);
    chk("ready_before_cmd", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_len   = len;
    @(negedge clk);
    lat = 1;
    trace[1] = int'(q);
    chk("ready_drop_after_accept", int'(cmd_ready), 0);
    if (!hold) begin
      cmd_valid = 1'b0;
    end else begin
      cmd_data = ~data;
      cmd_len  = 8'd9;
    end
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      trace[lat] = int'(q);
      if (hold) cmd_data = cmd_data + 1'b1;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  int lat;
  bit seen_done;

  initial begin
    rst       = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_data  = 4'hF;
    cmd_len   = '0;

    // Reset state, with a command presented while in reset.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_q", int'(q), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_jk", int'({j_mon, k_mon}), 0);
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", int'(cmd_ready), 1);

    // LOAD 1010
    run_cmd(2'b00, 4'b1010, 8'd0, 1'b0, lat);
    chk("load_lat", lat, 2);
    chk("load_q", int'(q), 4'b1010);
    @(negedge clk);
    chk("load_done_single", int'(done), 0);

    // CLEAR / TOGGLE from 1111
    run_cmd(2'b00, 4'b1111, 8'd0, 1'b0, lat);
    chk("load_f_q", int'(q), 4'b1111);
    run_cmd(2'b01, 4'b0110, 8'd0, 1'b0, lat);
    chk("clear_lat", lat, 2);
    chk("clear_q", int'(q), 4'b1001);
    run_cmd(2'b10, 4'b0011, 8'd0, 1'b0, lat);
    chk("toggle_lat", lat, 2);
    chk("toggle_q", int'(q), 4'b1010);

    // COUNT 5 from 1101, wrapping through 0000
    run_cmd(2'b00, 4'b1101, 8'd0, 1'b0, lat);
    run_cmd(2'b11, 4'b0000, 8'd5, 1'b0, lat);
    chk("count5_lat", lat, 6);
    chk("count5_step1", trace[2], 4'b1110);
    chk("count5_step2", trace[3], 4'b1111);
    chk("count5_step3", trace[4], 4'b0000);
    chk("count5_step4", trace[5], 4'b0001);
    chk("count5_step5", trace[6], 4'b0010);

    // COUNT with zero length
    run_cmd(2'b11, 4'b1111, 8'd0, 1'b0, lat);
    chk("count0_lat", lat, 2);
    chk("count0_q", int'(q), 4'b0010);

    // TOGGLE with valid held and data changing while busy
    run_cmd(2'b10, 4'b1111, 8'd0, 1'b1, lat);
    chk("hold_lat", lat, 2);
    chk("hold_q", int'(q), 4'b1101);
    @(negedge clk);
    chk("hold_no_accept_in_done", int'(busy), 0);
    chk("hold_ready_idle", int'(cmd_ready), 1);
    cmd_valid = 1'b0;

    // Reset during the third EXEC cycle of COUNT 10
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_data  = 4'b0000;
    cmd_len   = 8'd10;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_before", int'(busy), 1);
    chk("abort_q_before", int'(q), 4'b1111);
    rst = 1'b0;
    #1;
    chk("abort_q_cleared", int'(q), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b1;
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    chk("abort_no_done", int'(seen_done), 0);
    chk("abort_ready", int'(cmd_ready), 1);

    run_cmd(2'b00, 4'b0101, 8'd0, 1'b0, lat);
    chk("post_abort_lat", lat, 2);
    chk("post_abort_q", int'(q), 4'b0101);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

endmodule
